main_kernel_out_serializer: RTL and testbench
=============================================

MAIN_KERNEL_OUT_SERIALIZER -- requirements
Module: main_kernel_out_serializer

Interface
REQ-001 SHALL have parameter STREAMW, default 34, width of each kernel output lane and of dout.
REQ-002 SHALL have parameter DEPTH, default 4, element FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter NELEM, default 1024, elements per run; at least 1.
REQ-004 SHALL have parameter CNTW, default 32, width of the element counters.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-low reset; sampled on rising clk.
REQ-008 start  in  1  single-cycle pulse that begins a run.
REQ-009 ivalid  in  1  element valid; driven by the kernel top's ovalid.
REQ-010 iready  out  1  element accept; drives the kernel top's oready_un/xn/vn/yn.
REQ-011 un, xn, vn, yn  in  STREAMW each  kernel output lanes for one element.
REQ-012 dout  out  STREAMW  serialized lane data.
REQ-013 lane  out  2  lane tag of dout: 0=un, 1=xn, 2=vn, 3=yn.
REQ-014 ovalid  out  1  dout/lane/olast valid.
REQ-015 oready  in  1  downstream accept.
REQ-016 olast  out  1  marks lane 3 of element NELEM-1.
REQ-017 done  out  1  high while in state DONE.
REQ-018 elem_count  out  CNTW  number of elements fully emitted in the current run.

Function
REQ-019 SHALL implement the states IDLE, RUN and DONE.
REQ-020 IDLE -> RUN on start; RUN -> DONE on the handshake carrying olast; DONE -> RUN on start; start in RUN SHALL be ignored.
REQ-021 On any transition into RUN, the accept counter, elem_count and lane SHALL be cleared; FIFO is empty by construction.
REQ-022 iready SHALL be (state==RUN) & (fifo_count<DEPTH) & (accepted<NELEM), derived from registered state only, with no combinational path from oready.
REQ-023 An element SHALL be pushed, all four lanes together, iff ivalid&iready; accepted SHALL increment on each push.
REQ-024 A push and a pop in the same cycle SHALL both occur; fifo_count unchanged. When full, no push SHALL occur even if a pop happens that cycle (no bypass).
REQ-025 ovalid SHALL be (fifo_count>0); dout SHALL be the head-entry lane selected by lane; latency from push to first ovalid is 1 cycle.
REQ-026 On ovalid&oready: if lane<3, lane increments; if lane==3, lane returns to 0, the head is popped and elem_count increments.
REQ-027 When ovalid is high and oready is low, dout, lane and olast SHALL hold stable.
REQ-028 olast SHALL be ovalid & (lane==3) & (elem_count==NELEM-1).
REQ-029 Counters SHALL not wrap within a run; NELEM SHALL fit in CNTW bits.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While rst==0 at a clock edge: state=IDLE, fifo_count=0, pointers=0, lane=0, accepted=0, elem_count=0.
REQ-032 Outputs under reset: iready=0, ovalid=0, olast=0, done=0. dout is don't-care while ovalid=0.
REQ-033 Reset asserted mid-run SHALL discard buffered elements and partially emitted lanes. No output handshake SHALL occur in the reset cycle.

Verification
REQ-034 Basic run: NELEM=2, start, push (un,xn,vn,yn)=(1,2,3,4),(5,6,7,8), oready=1 -> dout 1,2,3,4,5,6,7,8, lane 0..3 twice, olast only with dout=8, then done=1 and elem_count=2.
REQ-035 Full FIFO: DEPTH=4, oready=0, ivalid=1 -> exactly 4 pushes, then iready=0. One output handshake -> iready stays 0 until the fourth lane pops, then returns to 1.
REQ-036 Backpressure: oready toggles 1010... -> every lane emitted exactly once, in order, with dout stable during stalls.
REQ-037 Accept limit: NELEM=3, ivalid held high -> exactly 3 pushes, iready=0 thereafter, and start in RUN is ignored.
REQ-038 Reset mid-run: rst=0 after 5 lane handshakes -> next cycle ovalid=0, elem_count=0, state IDLE. A new start yields a clean run beginning at lane 0.
REQ-039 Restart: start in DONE -> done=0, elem_count=0, and iready=1 on the following cycle.

Source files
------------

// File: rtl/main_kernel_out_serializer.sv
// Serializes the four kernel output lanes (un, xn, vn, yn) of each element into one stream,
// buffering whole elements in a small FIFO and tagging every beat with its lane number.
module main_kernel_out_serializer #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 4,
    parameter int NELEM   = 1024,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ivalid,
    output logic               iready,
    input  logic [STREAMW-1:0] un,
    input  logic [STREAMW-1:0] xn,
    input  logic [STREAMW-1:0] vn,
    input  logic [STREAMW-1:0] yn,
    output logic [STREAMW-1:0] dout,
    output logic [1:0]         lane,
    output logic               ovalid,
    input  logic               oready,
    output logic               olast,
    output logic               done,
    output logic [CNTW-1:0]    elem_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [CNTW-1:0] NELEM_C  = CNTW'(NELEM);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NELEM - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4*STREAMW-1:0] mem [DEPTH];
    logic [4*STREAMW-1:0] head;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          fifo_count;
    logic [CNTW-1:0]      accepted;
    logic                 push;
    logic                 pop;
    logic                 out_hs;
    logic                 run_entry;

    // Outputs are gated by rst so nothing looks valid or ready while reset is held.
    assign iready    = rst && (state == RUN) && (fifo_count < DEPTH_C) && (accepted < NELEM_C);
    assign ovalid    = rst && (fifo_count != '0);
    assign done      = rst && (state == DONE);
    assign olast     = ovalid && (lane == 2'd3) && (elem_count == LAST_IDX);
    assign push      = ivalid && iready;
    assign out_hs    = ovalid && oready;
    assign pop       = out_hs && (lane == 2'd3);
    assign run_entry = start && (state != RUN);
    assign head      = mem[rd_ptr];

    always_comb begin
        dout = head[STREAMW-1:0];
        case (lane)
            2'd0:    dout = head[STREAMW-1:0];
            2'd1:    dout = head[2*STREAMW-1:STREAMW];
            2'd2:    dout = head[3*STREAMW-1:2*STREAMW];
            default: dout = head[4*STREAMW-1:3*STREAMW];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (out_hs && olast) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Element storage keeps all four lanes of an element in one word, un in the low bits.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {yn, vn, xn, un};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A run only starts from IDLE or DONE, where the FIFO is already drained.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane       <= 2'd0;
            accepted   <= '0;
            elem_count <= '0;
        end else if (run_entry) begin
            lane       <= 2'd0;
            accepted   <= '0;
            elem_count <= '0;
        end else begin
            if (push)   accepted   <= accepted + 1'b1;
            if (out_hs) lane       <= lane + 2'd1;
            if (pop)    elem_count <= elem_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_main_kernel_out_serializer.sv
// Randomized scoreboard bench: a lane-level reference model predicts every beat, and a
// negedge monitor compares the DUT outputs against it.
module tb_main_kernel_out_serializer;

    localparam int STREAMW = 34;
    localparam int DEPTH   = 4;
    localparam int NELEM   = 6;
    localparam int CNTW    = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               ivalid = 1'b0;
    logic               oready = 1'b0;
    logic [STREAMW-1:0] un = '0;
    logic [STREAMW-1:0] xn = '0;
    logic [STREAMW-1:0] vn = '0;
    logic [STREAMW-1:0] yn = '0;
    logic               iready;
    logic [STREAMW-1:0] dout;
    logic [1:0]         lane;
    logic               ovalid;
    logic               olast;
    logic               done;
    logic [CNTW-1:0]    elem_count;

    main_kernel_out_serializer #(
        .STREAMW(STREAMW),
        .DEPTH  (DEPTH),
        .NELEM  (NELEM),
        .CNTW   (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ivalid    (ivalid),
        .iready    (iready),
        .un        (un),
        .xn        (xn),
        .vn        (vn),
        .yn        (yn),
        .dout      (dout),
        .lane      (lane),
        .ovalid    (ovalid),
        .oready    (oready),
        .olast     (olast),
        .done      (done),
        .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [STREAMW-1:0] data;
        logic [1:0]         lane;
        logic               last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    hs_total = 0;
    bit    m_run = 0;
    bit    m_done = 0;
    int    m_accepted = 0;
    int    m_emitted = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works in whole elements and a flat count of emitted beats.
    always @(negedge clk) begin : monitor
        int    occ;
        bit    exp_iready;
        bit    was_run;
        beat_t b;
        logic [STREAMW-1:0] lanes [4];
        if (!rst) begin
            checkOutput("iready_rst", 64'(iready), 64'd0);
            checkOutput("ovalid_rst", 64'(ovalid), 64'd0);
            checkOutput("olast_rst", 64'(olast), 64'd0);
            checkOutput("done_rst", 64'(done), 64'd0);
            m_run = 0;
            m_done = 0;
            m_accepted = 0;
            m_emitted = 0;
            exp_q.delete();
        end else begin
            occ = m_accepted - m_emitted / 4;
            exp_iready = m_run && (occ < DEPTH) && (m_accepted < NELEM);
            checkOutput("iready", 64'(iready), 64'(exp_iready));
            checkOutput("ovalid", 64'(ovalid), 64'(exp_q.size() != 0));
            checkOutput("done", 64'(done), 64'(m_done));
            checkOutput("elem_count", 64'(elem_count), 64'(m_emitted / 4));
            if (exp_q.size() != 0) begin
                checkOutput("dout", 64'(dout), 64'(exp_q[0].data));
                checkOutput("lane", 64'(lane), 64'(exp_q[0].lane));
                checkOutput("olast", 64'(olast), 64'(exp_q[0].last));
            end else begin
                checkOutput("olast_idle", 64'(olast), 64'd0);
            end
            was_run = m_run;
            if (exp_q.size() != 0 && oready) begin
                b = exp_q.pop_front();
                m_emitted++;
                hs_total++;
                if (b.last) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
            if (ivalid && exp_iready) begin
                lanes[0] = un;
                lanes[1] = xn;
                lanes[2] = vn;
                lanes[3] = yn;
                for (int i = 0; i < 4; i++) begin
                    b.data = lanes[i];
                    b.lane = 2'(i);
                    b.last = (m_accepted == NELEM - 1) && (i == 3);
                    exp_q.push_back(b);
                end
                m_accepted++;
            end
            if (start && !was_run) begin
                m_run = 1;
                m_done = 0;
                m_accepted = 0;
                m_emitted = 0;
            end
        end
    end

    task automatic applyStimulus(input bit st, input bit iv, input bit ordy);
        @(posedge clk);
        #1;
        start  = st;
        ivalid = iv;
        oready = ordy;
        un = STREAMW'({$urandom(), $urandom()});
        xn = STREAMW'({$urandom(), $urandom()});
        vn = STREAMW'({$urandom(), $urandom()});
        yn = STREAMW'({$urandom(), $urandom()});
    endtask

    // mode 0: always ready, 1: oready toggles 1010..., 2: random; ivalid random unless held.
    task automatic runUntilDone(input int mode, input bit hold_valid);
        bit tgl = 1'b1;
        bit ok = 1'b0;
        bit ordy;
        for (int c = 0; c < 500; c++) begin
            if (m_done) begin
                ok = 1'b1;
                break;
            end
            case (mode)
                0:       ordy = 1'b1;
                1:       ordy = tgl;
                default: ordy = 1'($urandom_range(0, 1));
            endcase
            tgl = ~tgl;
            applyStimulus(1'b0, hold_valid ? 1'b1 : 1'($urandom_range(0, 1)), ordy);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL run_timeout: done not reached, mode %0d", mode);
        end
    endtask

    initial begin
        int base;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Basic run with ivalid held: also exercises the accept limit.
        applyStimulus(1'b1, 1'b0, 1'b1);
        runUntilDone(0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Restart from DONE, fill the FIFO under backpressure, then a single beat.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilDone(2, 1'b0);

        // Toggling backpressure.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runUntilDone(1, 1'b0);

        // Reset after five beats have been emitted, then a clean run.
        applyStimulus(1'b1, 1'b1, 1'b1);
        base = hs_total;
        for (int c = 0; c < 100 && hs_total < base + 5; c++) applyStimulus(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runUntilDone(2, 1'b0);

        // Random runs with stray start pulses.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (5) applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)));
            runUntilDone(2, 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
